// File: rtl/bootloader_pkg.sv
// Shared bootloader definitions used by the word serializer and the byte-to-word assembler.
//   WORD_WIDTH     : word width in bits
//   BYTE_WIDTH     : byte width in bits
//   BYTES_PER_WORD : bytes carried by one word
//   ser_state_e    : IDLE (no word held) / SEND (word held, bytes pending)
package bootloader_pkg;

    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned BYTE_WIDTH     = 8;
    localparam int unsigned BYTES_PER_WORD = WORD_WIDTH / BYTE_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/word_serializer.sv
// Splits words from instruction-memory readback into little-endian bytes for the TX FIFO.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   word_in/valid     : word source; word_ready acknowledges acceptance
//   byte_out/valid    : byte sink; byte_ready acknowledges acceptance
//   busy              : a word is held with bytes still outstanding
//   words_sent        : wrapping count of fully transmitted words
module word_serializer
    import bootloader_pkg::ser_state_e, bootloader_pkg::IDLE, bootloader_pkg::SEND;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic [BYTE_WIDTH-1:0] byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  busy,
    output logic [15:0]           words_sent
);

    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH / BYTE_WIDTH - 1);

    ser_state_e            state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]      words_sent_q, words_sent_d;

    logic last_byte;
    logic byte_hs;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            byte_idx_q   <= '0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            words_sent_q <= words_sent_d;
        end
    end

    // Next-state and handshake logic; a new word may be taken on the same edge the last byte leaves.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        words_sent_d = words_sent_q;
        word_ready   = 1'b0;

        last_byte = (byte_idx_q == LAST_IDX);
        byte_hs   = (state_q == SEND) && byte_ready;

        case (state_q)
            IDLE: begin
                word_ready = !rst;
                if (word_valid) begin
                    state_d    = SEND;
                    shift_d    = word_in;
                    byte_idx_d = '0;
                end
            end
            SEND: begin
                word_ready = !rst && last_byte && byte_ready;
                if (byte_hs) begin
                    if (last_byte) begin
                        words_sent_d = words_sent_q + CNT_W'(1);
                        if (word_valid) begin
                            shift_d    = word_in;
                            byte_idx_d = '0;
                        end else begin
                            state_d    = IDLE;
                            byte_idx_d = '0;
                        end
                    end else begin
                        shift_d    = shift_q >> BYTE_WIDTH;
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_out   = shift_q[BYTE_WIDTH-1:0];
    assign byte_valid = (state_q == SEND);
    assign busy       = byte_valid;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_word_serializer.sv
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        busy;
    logic [15:0] words_sent;

    int passed = 0;
    int total  = 0;

    // Expected byte stream: bit 8 marks the final byte of a word.
    logic [8:0]  exp_q[$];
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    word_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .words_sent (words_sent)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of stimulus on the falling edge.
    task automatic cyc(input logic wv, input logic [31:0] w, input logic br, input logic r = 1'b0);
        @(negedge clk);
        rst        = r;
        word_valid = wv;
        word_in    = w;
        byte_ready = br;
    endtask

    // Monitor / reference model: predicts handshakes from the queue occupancy and checks outputs
    // in the low phase, before the rising edge that consumes these inputs.
    always begin
        logic       exp_ready;
        logic [8:0] e;
        @(negedge clk);
        #2;
        if (rst) begin
            chk("rst_byte_valid", 32'(byte_valid), 32'd0);
            chk("rst_busy",       32'(busy),       32'd0);
            chk("rst_byte_out",   32'(byte_out),   32'd0);
            chk("rst_word_ready", 32'(word_ready), 32'd0);
            chk("rst_words_sent", 32'(words_sent), 32'd0);
            exp_q.delete();
            exp_cnt = '0;
        end else begin
            exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && byte_ready);
            chk("word_ready", 32'(word_ready), 32'(exp_ready));
            chk("byte_valid", 32'(byte_valid), 32'(exp_q.size() != 0));
            chk("busy",       32'(busy),       32'(exp_q.size() != 0));
            chk("words_sent", 32'(words_sent), 32'(exp_cnt));
            if (exp_q.size() != 0) begin
                chk("byte_out", 32'(byte_out), 32'(exp_q[0][7:0]));
                if (byte_ready) begin
                    e = exp_q.pop_front();
                    if (e[8]) exp_cnt = exp_cnt + 16'd1;
                end
            end
            if (word_valid && exp_ready) begin
                for (int i = 0; i < 4; i++)
                    exp_q.push_back({(i == 3), 8'((word_in >> (8 * i)) & 32'hFF)});
            end
        end
    end

    initial begin
        // Reset held for a few cycles.
        repeat (3) cyc(1'b1, 32'h5555_5555, 1'b1, 1'b1);

        // Single word, first handshake right after reset release.
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1);
        repeat (6) cyc(1'b0, 32'h0, 1'b1);

        // Back-to-back words with word_valid held.
        cyc(1'b1, 32'h0302_0100, 1'b1);
        repeat (4) cyc(1'b1, 32'h0706_0504, 1'b1);
        repeat (6) cyc(1'b0, 32'h0, 1'b1);

        // Backpressure during byte 1.
        cyc(1'b1, 32'h1122_3344, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        repeat (3) cyc(1'b0, 32'h0, 1'b0);
        repeat (5) cyc(1'b0, 32'h0, 1'b1);

        // Handoff blocked while byte 3 is stalled.
        cyc(1'b1, 32'hCAFE_F00D, 1'b1);
        repeat (3) cyc(1'b1, 32'h1234_5678, 1'b1);
        repeat (3) cyc(1'b1, 32'h1234_5678, 1'b0);
        cyc(1'b1, 32'h1234_5678, 1'b1);
        repeat (6) cyc(1'b0, 32'h0, 1'b1);

        // Reset after byte 1 of a word, then a fresh word.
        cyc(1'b1, 32'hAABB_CCDD, 1'b1);
        repeat (2) cyc(1'b0, 32'h0, 1'b1);
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b1);
        cyc(1'b1, 32'h0102_0304, 1'b1);
        repeat (6) cyc(1'b0, 32'h0, 1'b1);

        // Counter wrap: preset near the top, then send two words.
        @(negedge clk);
        word_valid = 1'b0;
        force dut.words_sent_q = 16'hFFFE;
        exp_cnt = 16'hFFFE;
        #1 release dut.words_sent_q;
        cyc(1'b1, 32'h89AB_CDEF, 1'b1);
        repeat (4) cyc(1'b1, 32'h7654_3210, 1'b1);
        repeat (6) cyc(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        #3;
        chk("wrap_words_sent", 32'(words_sent), 32'h0000);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 1) == 1), $urandom(), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 499) == 0));
        end
        repeat (8) cyc(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
